// File: rtl/instruction_sequencer.sv
//------------------------------------------------------------------------------
// Module      : instruction_sequencer
// Description : Fetch/execute sequencer for a tiny accumulator machine with
//               four general registers and an external combinational ALU.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module instruction_sequencer #(
    parameter int OPCODE_WIDTH   = 4,
    parameter int REGISTER_WIDTH = 8,
    parameter int ADDRESS_WIDTH  = 8
) (
    input  logic                      clock,
    input  logic                      resetN,
    output logic [ADDRESS_WIDTH-1:0]  memAddr,
    output logic                      memReq,
    input  logic                      memReady,
    input  logic [15:0]               memData,
    output logic [OPCODE_WIDTH-1:0]   opCode,
    output logic [REGISTER_WIDTH-1:0] register1,
    output logic [REGISTER_WIDTH-1:0] accumulator,
    input  logic [REGISTER_WIDTH-1:0] aluResult,
    output logic                      halted
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_EXECUTE = 2'd2,
        ST_HALT    = 2'd3
    } state_t;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_INC   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_NOT   = 4'd4;
    localparam logic [3:0] OP_LOADI = 4'd8;
    localparam logic [3:0] OP_STORE = 4'd9;
    localparam logic [3:0] OP_MOVE  = 4'd10;
    localparam logic [3:0] OP_JUMPZ = 4'd12;
    localparam logic [3:0] OP_JUMP  = 4'd13;
    localparam logic [3:0] OP_HALT  = 4'd15;

    state_t                    state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]  pc_q, pc_d;
    logic [15:0]               ir_q, ir_d;
    logic [REGISTER_WIDTH-1:0] acc_q, acc_d;
    logic [REGISTER_WIDTH-1:0] regs_q [4];
    logic [REGISTER_WIDTH-1:0] regs_d [4];

    logic [3:0]                ir_op;
    logic [1:0]                ir_idx;
    logic [REGISTER_WIDTH-1:0] imm_reg;
    logic [ADDRESS_WIDTH-1:0]  imm_addr;
    logic                      unused_ir_bits;

    assign ir_op          = ir_q[15:12];
    assign ir_idx         = ir_q[11:10];
    assign imm_reg        = REGISTER_WIDTH'(ir_q[7:0]);
    assign imm_addr       = ADDRESS_WIDTH'(ir_q[7:0]);
    assign unused_ir_bits = ^ir_q[9:8];

    // ALU operands come straight from ir/regs so they hold for the whole EXECUTE cycle
    assign opCode      = OPCODE_WIDTH'(ir_op);
    assign register1   = regs_q[ir_idx];
    assign accumulator = acc_q;
    assign memReq      = (state_q == ST_FETCH);
    assign memAddr     = pc_q;
    assign halted      = (state_q == ST_HALT);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        acc_d   = acc_q;
        regs_d  = regs_q;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                if (memReady) begin
                    ir_d    = memData;
                    pc_d    = pc_q + ADDRESS_WIDTH'(1);
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                state_d = ST_FETCH;
                case (ir_op)
                    OP_ADD, OP_INC, OP_AND, OP_OR, OP_NOT: acc_d = aluResult;
                    OP_LOADI: acc_d = imm_reg;
                    OP_STORE: regs_d[ir_idx] = acc_q;
                    OP_MOVE:  acc_d = regs_q[ir_idx];
                    OP_JUMPZ: begin
                        if (acc_q == '0) pc_d = imm_addr;
                    end
                    OP_JUMP:  pc_d = imm_addr;
                    OP_HALT:  state_d = ST_HALT;
                    default: ;
                endcase
            end
            default: state_d = ST_HALT;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            acc_q   <= '0;
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
            regs_q  <= regs_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instruction_sequencer.sv
//------------------------------------------------------------------------------
// Module      : tb_instruction_sequencer
// Description : Self-checking bench: program memory, behavioural ALU and a
//               fetch-address scoreboard around instruction_sequencer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_instruction_sequencer;

    logic        clock = 1'b0;
    logic        resetN = 1'b0;
    logic [7:0]  memAddr;
    logic        memReq;
    logic        memReady = 1'b1;
    logic [15:0] memData;
    logic [3:0]  opCode;
    logic [7:0]  register1;
    logic [7:0]  accumulator;
    logic [7:0]  aluResult;
    logic        halted;

    logic [15:0] mem [0:255];
    logic [7:0]  exp_q [$];
    int          checks = 0;
    int          errors = 0;

    instruction_sequencer #(
        .OPCODE_WIDTH  (4),
        .REGISTER_WIDTH(8),
        .ADDRESS_WIDTH (8)
    ) dut (
        .clock      (clock),
        .resetN     (resetN),
        .memAddr    (memAddr),
        .memReq     (memReq),
        .memReady   (memReady),
        .memData    (memData),
        .opCode     (opCode),
        .register1  (register1),
        .accumulator(accumulator),
        .aluResult  (aluResult),
        .halted     (halted)
    );

    always #5 clock = ~clock;

    assign memData = mem[memAddr];

    always_comb begin
        aluResult = 8'h00;
        case (opCode)
            4'd0: aluResult = accumulator + register1;
            4'd1: aluResult = accumulator + 8'd1;
            4'd2: aluResult = accumulator & register1;
            4'd3: aluResult = accumulator | register1;
            4'd4: aluResult = ~accumulator;
            default: aluResult = 8'h00;
        endcase
    end

    // One clock; any fetch handshake completing on this edge is scored first
    task automatic tick();
        logic [7:0] e;
        if (memReq && memReady) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL fetch_addr: got unexpected fetch at %02h, required none", memAddr);
            end else begin
                e = exp_q.pop_front();
                if (memAddr !== e) begin
                    errors++;
                    $display("FAIL fetch_addr: got %02h, required %02h", memAddr, e);
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic load_fill();
        for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
    endtask

    task automatic apply_reset();
        resetN = 1'b0;
        exp_q.delete();
        @(posedge clock); #1;
        @(posedge clock); #1;
        resetN = 1'b1;
    endtask

    task automatic run_until_halt(input int budget);
        int n;
        n = 0;
        while (!halted && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (!halted) begin
            errors++;
            $display("FAIL halt_timeout: halted=%0b after %0d cycles, required 1", halted, n);
        end
    endtask

    task automatic check_queue_empty(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_queue: %0d fetches outstanding, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        load_fill();
        resetN = 1'b0;
        @(posedge clock); #1;
        checks++;
        if ({memReq, memAddr, halted, opCode, register1, accumulator} !== 30'd0) begin
            errors++;
            $display("FAIL reset_values: req=%0b addr=%02h halt=%0b op=%0h r1=%02h acc=%02h, required all 0",
                     memReq, memAddr, halted, opCode, register1, accumulator);
        end
    endtask

    task automatic test_basic();
        load_fill();
        mem[0] = 16'h8005; mem[1] = 16'h1000; mem[2] = 16'hF000;
        memReady = 1'b1;
        apply_reset();
        exp_q.push_back(8'h00); exp_q.push_back(8'h01); exp_q.push_back(8'h02);
        repeat (6) tick();
        checks++;
        if (halted !== 1'b0) begin
            errors++;
            $display("FAIL basic_early_halt: halted=%0b at cycle 6, required 0", halted);
        end
        tick();
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL basic_halt_c7: halted=%0b at cycle 7, required 1", halted);
        end
        checks++;
        if (accumulator !== 8'h06) begin
            errors++;
            $display("FAIL basic_acc: got %02h, required 06", accumulator);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (memReq !== 1'b0 || halted !== 1'b1 || accumulator !== 8'h06) begin
                errors++;
                $display("FAIL basic_frozen: req=%0b halt=%0b acc=%02h, required 0 1 06", memReq, halted, accumulator);
            end
        end
        check_queue_empty("basic");
    endtask

    task automatic test_wait();
        load_fill();
        mem[0] = 16'h8033; mem[1] = 16'hF000;
        memReady = 1'b0;
        apply_reset();
        exp_q.push_back(8'h00);
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (memReq !== 1'b1 || memAddr !== 8'h00 || opCode !== 4'h0) begin
                errors++;
                $display("FAIL wait_hold: req=%0b addr=%02h op=%0h, required 1 00 0", memReq, memAddr, opCode);
            end
            tick();
        end
        memReady = 1'b1;
        checks++;
        if (memReq !== 1'b1 || memAddr !== 8'h00) begin
            errors++;
            $display("FAIL wait_ready_cycle: req=%0b addr=%02h, required 1 00", memReq, memAddr);
        end
        tick();
        checks++;
        if (opCode !== 4'h8) begin
            errors++;
            $display("FAIL wait_ir_load: opCode=%0h, required 8", opCode);
        end
        exp_q.push_back(8'h01);
        run_until_halt(20);
        checks++;
        if (accumulator !== 8'h33) begin
            errors++;
            $display("FAIL wait_acc: got %02h, required 33", accumulator);
        end
        check_queue_empty("wait");
    endtask

    task automatic test_wrap();
        load_fill();
        mem[0] = 16'h8080; mem[1] = 16'h9800; mem[2] = 16'h0800; mem[3] = 16'hF000;
        memReady = 1'b1;
        apply_reset();
        for (int i = 0; i < 4; i++) exp_q.push_back(8'(i));
        repeat (6) tick();
        checks++;
        if (opCode !== 4'h0 || register1 !== 8'h80) begin
            errors++;
            $display("FAIL wrap_operands: op=%0h r1=%02h, required 0 80", opCode, register1);
        end
        tick();
        checks++;
        if (accumulator !== 8'h00) begin
            errors++;
            $display("FAIL wrap_acc: got %02h, required 00", accumulator);
        end
        run_until_halt(20);
        check_queue_empty("wrap");
    endtask

    task automatic test_alu_ops();
        load_fill();
        mem[0] = 16'h800F; mem[1] = 16'h9400; mem[2] = 16'h803C; mem[3] = 16'h2400;
        mem[4] = 16'h3400; mem[5] = 16'h4000; mem[6] = 16'h6000; mem[7] = 16'h9C00;
        mem[8] = 16'h8000; mem[9] = 16'hAC00; mem[10] = 16'hF000;
        memReady = 1'b1;
        apply_reset();
        for (int i = 0; i < 11; i++) exp_q.push_back(8'(i));
        run_until_halt(60);
        checks++;
        if (accumulator !== 8'hF0) begin
            errors++;
            $display("FAIL alu_acc: got %02h, required F0", accumulator);
        end
        check_queue_empty("alu");
    endtask

    task automatic test_jumpz();
        load_fill();
        mem[0] = 16'h8000; mem[1] = 16'hC010; mem[2] = 16'h1000; mem[16] = 16'hF000;
        memReady = 1'b1;
        apply_reset();
        exp_q.push_back(8'h00); exp_q.push_back(8'h01); exp_q.push_back(8'h10);
        run_until_halt(20);
        check_queue_empty("jumpz_taken");
        mem[0] = 16'h8001; mem[2] = 16'hF000;
        apply_reset();
        exp_q.push_back(8'h00); exp_q.push_back(8'h01); exp_q.push_back(8'h02);
        run_until_halt(20);
        checks++;
        if (accumulator !== 8'h01) begin
            errors++;
            $display("FAIL jumpz_nt_acc: got %02h, required 01", accumulator);
        end
        check_queue_empty("jumpz_not_taken");
    endtask

    task automatic test_jump_wrap();
        load_fill();
        mem[0] = 16'hD0FF; mem[255] = 16'h5000;
        memReady = 1'b1;
        apply_reset();
        exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
        repeat (6) tick();
        checks++;
        if (opCode !== 4'hD) begin
            errors++;
            $display("FAIL jump_wrap_op: opCode=%0h, required D", opCode);
        end
        check_queue_empty("jump_wrap");
    endtask

    task automatic test_reset_mid();
        load_fill();
        mem[0] = 16'h8042; mem[1] = 16'h9000; mem[2] = 16'hF000;
        memReady = 1'b1;
        apply_reset();
        exp_q.push_back(8'h00); exp_q.push_back(8'h01);
        repeat (5) tick();
        memReady = 1'b0;
        repeat (2) tick();
        checks++;
        if (memReq !== 1'b1 || memAddr !== 8'h02 || accumulator !== 8'h42) begin
            errors++;
            $display("FAIL mid_pre_reset: req=%0b addr=%02h acc=%02h, required 1 02 42", memReq, memAddr, accumulator);
        end
        resetN = 1'b0;
        #1;
        checks++;
        if (memReq !== 1'b0 || accumulator !== 8'h00 || memAddr !== 8'h00 || register1 !== 8'h00) begin
            errors++;
            $display("FAIL mid_async_reset: req=%0b acc=%02h addr=%02h r1=%02h, required 0 00 00 00",
                     memReq, accumulator, memAddr, register1);
        end
        resetN = 1'b1;
        memReady = 1'b1;
        exp_q.push_back(8'h00);
        tick();
        checks++;
        if (memReq !== 1'b1 || memAddr !== 8'h00) begin
            errors++;
            $display("FAIL mid_refetch: req=%0b addr=%02h, required 1 00", memReq, memAddr);
        end
        tick();
        checks++;
        if (opCode !== 4'h8) begin
            errors++;
            $display("FAIL mid_refetch_ir: opCode=%0h, required 8", opCode);
        end
        check_queue_empty("reset_mid");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait();
        test_wrap();
        test_alu_ops();
        test_jumpz();
        test_jump_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instruction_sequencer.md
INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 SHALL have parameter OPCODE_WIDTH, default 4: width of the opCode field and port.
REQ-002 SHALL have parameter REGISTER_WIDTH, default 8: width of accumulator, registers, ALU operands and result.
REQ-003 SHALL have parameter ADDRESS_WIDTH, default 8: width of the program counter and memAddr.
REQ-004 SHALL have port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port resetN, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port memAddr, output, ADDRESS_WIDTH: program memory fetch address.
REQ-007 SHALL have port memReq, output, 1: fetch request.
REQ-008 SHALL have port memReady, input, 1: fetch data valid this cycle.
REQ-009 SHALL have port memData, input, 16: instruction word {opcode[15:12], regIndex[11:10], unused[9:8], immediate[7:0]}.
REQ-010 SHALL have port opCode, output, OPCODE_WIDTH: operation sent to the ALU.
REQ-011 SHALL have port register1, output, REGISTER_WIDTH: second ALU operand.
REQ-012 SHALL have port accumulator, output, REGISTER_WIDTH: accumulator contents and first ALU operand.
REQ-013 SHALL have port aluResult, input, REGISTER_WIDTH: combinational ALU result.
REQ-014 SHALL have port halted, output, 1: high while in HALT.

Function
REQ-015 SHALL implement states IDLE, FETCH, EXECUTE and HALT, with four internal registers r0-r3, a program counter pc and an instruction register ir.
REQ-016 SHALL move IDLE -> FETCH unconditionally on the first rising edge after reset release.
REQ-017 SHALL drive memReq=1 and memAddr=pc only in FETCH; memReq=0 in every other state.
REQ-018 SHALL hold memAddr stable while memReq=1 and stay in FETCH until memReady=1 is sampled; memReady is ignored outside FETCH.
REQ-019 SHALL, on the edge where memReady=1 in FETCH, load ir<=memData, set pc<=pc+1 modulo 2^ADDRESS_WIDTH (0xFF wraps to 0x00), and go to EXECUTE.
REQ-020 SHALL drive opCode=ir[15:12] and register1=r[ir[11:10]] continuously, so ALU inputs are stable for the whole EXECUTE cycle.
REQ-021 SHALL take EXECUTE as exactly one cycle and then return to FETCH, except HALT; an instruction costs 2 cycles plus memory wait cycles.
REQ-022 SHALL, for opcodes ADD=0, INCREMENT=1, AND=2, OR=3 and NOT=4, latch accumulator<=aluResult at the end of EXECUTE without any width extension or carry retention.
REQ-023 SHALL, for LOADI=8, set accumulator<=immediate.
REQ-024 SHALL, for STORE=9, set r[regIndex]<=accumulator.
REQ-025 SHALL, for MOVE=10, set accumulator<=r[regIndex].
REQ-026 SHALL, for JUMPZ=12, set pc<=immediate if accumulator==0, overriding the REQ-019 increment; otherwise leave pc unchanged.
REQ-027 SHALL, for JUMP=13, set pc<=immediate unconditionally.
REQ-028 SHALL, for HALT=15, enter HALT, keep halted=1, keep memReq=0 and keep all state frozen until reset.
REQ-029 SHALL treat opcodes 5-7, 11 and 14 as NOP: no register, accumulator or pc change beyond REQ-019.
REQ-030 SHALL update accumulator only in EXECUTE, never in FETCH or IDLE.

Reset
REQ-031 SHALL, while resetN=0, immediately force state=IDLE and pc, ir, accumulator and r0-r3 to 0, which gives memReq=0, memAddr=0x00, halted=0, opCode=0 and register1=0.
REQ-032 SHALL, if reset asserts mid-FETCH or mid-EXECUTE, drop memReq in the same cycle and discard the in-flight instruction, with no partial writes.
REQ-033 SHALL, after reset release, issue its first fetch from address 0x00.

Verification
REQ-034 SHALL be verified by this scenario: program {LOADI 5, INCREMENT, HALT} at 0x00-0x02 with memReady tied high -> memAddr sequence 0,1,2; accumulator=6; halted=1 at cycle 7 after release; memReq stays 0 afterwards.
REQ-035 SHALL be verified by this scenario: memReady held low for 3 cycles during a fetch -> memReq=1 and memAddr unchanged for all 4 cycles, and ir is loaded only on the ready edge.
REQ-036 SHALL be verified by this scenario: {LOADI 0x80, STORE r2, ADD r2} -> register1=0x80 during ADD and accumulator=0x00 (8-bit wrap).
REQ-037 SHALL be verified by this scenario: {LOADI 0, JUMPZ 0x10} -> next memAddr=0x10; with LOADI 1 instead -> next memAddr=0x02.
REQ-038 SHALL be verified by this scenario: JUMP 0xFF with NOP at 0xFF -> the following fetch address is 0x00.
REQ-039 SHALL be verified by this scenario: resetN pulsed low during a memReady-low wait -> memReq=0 in the same cycle, accumulator=0, and the next fetch is at 0x00.
